// File: rtl/snos_pkg.sv
// Rate table, window helpers and shared types for the I2S rate detector.
package snos_pkg;

    typedef enum logic [1:0] {
        FS_1X = 2'd0,
        FS_2X = 2'd1,
        FS_4X = 2'd2,
        FS_8X = 2'd3
    } bitrate_e;

    typedef struct packed {
        logic     fam;
        bitrate_e rate;
    } rate_cls_t;

    localparam int N_FS = 8;

    // Index bit 0 is the family, bits 2:1 the rate multiple.
    localparam int unsigned FS_TAB [N_FS] = '{
        44100, 48000, 88200, 96000,
        176400, 192000, 352800, 384000
    };

    function automatic int unsigned nom_period(
        input int unsigned clk_hz,
        input int unsigned fs
    );
        return (clk_hz + fs / 2) / fs;
    endfunction

    function automatic int unsigned win_lo(
        input int unsigned clk_hz,
        input int unsigned fs
    );
        int unsigned n;
        n = nom_period(clk_hz, fs);
        return n - (n >> 5);
    endfunction

    function automatic int unsigned win_hi(
        input int unsigned clk_hz,
        input int unsigned fs
    );
        int unsigned n;
        n = nom_period(clk_hz, fs);
        return n + (n >> 5);
    endfunction

    function automatic rate_cls_t idx_cls(input logic [2:0] i);
        rate_cls_t c;
        c.fam  = i[0];
        c.rate = bitrate_e'(i[2:1]);
        return c;
    endfunction

    function automatic bit windows_disjoint(input int unsigned clk_hz);
        for (int i = 0; i < N_FS; i++) begin
            for (int j = i + 1; j < N_FS; j++) begin
                if (!(win_hi(clk_hz, FS_TAB[i]) < win_lo(clk_hz, FS_TAB[j]) ||
                      win_hi(clk_hz, FS_TAB[j]) < win_lo(clk_hz, FS_TAB[i])))
                    return 1'b0;
            end
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/i2s_rate_detect_if.sv
// LRCK input and rate-detect result bundle.
interface i2s_rate_detect_if #(
    parameter int CNT_W = 12
);
    import snos_pkg::*;

    logic             lrck;
    bitrate_e         bitrate;
    logic             fam_48;
    logic             locked;
    logic [CNT_W-1:0] period;
    logic             update;

    modport master (
        output lrck,
        input  bitrate, fam_48, locked, period, update
    );

    modport slave (
        input  lrck,
        output bitrate, fam_48, locked, period, update
    );
endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer with a rising-edge pulse on the synchronized level.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);
    logic s1_q, s2_q, prev_q;
    logic s1_d, s2_d, prev_d;

    always_comb begin
        s1_d   = d;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign rise = s2_q & ~prev_q;
endmodule

// File: rtl/i2s_rate_detect.sv
// Times LRCK periods against clk, classifies the sample rate and locks on agreement.
module i2s_rate_detect
    import snos_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 49_152_000,
    parameter int          CNT_W    = 12,
    parameter int          LOCK_N   = 4,
    parameter int          UNLOCK_N = 2
) (
    input logic               clk,
    input logic               reset,
    i2s_rate_detect_if.slave  bus
);
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
    localparam int HW = $clog2(LOCK_N + 1);
    localparam int MW = $clog2(UNLOCK_N + 1);

    if (!windows_disjoint(CLK_HZ)) begin : g_chk_win
        $error("rate windows overlap");
    end
    if (CNT_MAX * 10 <= 11 * nom_period(CLK_HZ, FS_TAB[0])) begin : g_chk_cnt
        $error("CNT_W too small for 44.1k period");
    end

    typedef enum logic {ACQ, LOCK} state_e;

    logic edge_p;

    sync_edge u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.lrck),
        .rise  (edge_p)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d;
    logic             armed_q, armed_d, meas_q, meas_d;
    rate_cls_t        cand_q, cand_d;
    logic [HW-1:0]    hit_q, hit_d;
    logic [MW-1:0]    miss_q, miss_d;
    bitrate_e         bitrate_q, bitrate_d;
    logic             fam_q, fam_d, locked_q, locked_d, update_q, update_d;

    logic [31:0] per_ext;
    logic [3:0]  hits;
    logic [2:0]  cls_idx;
    logic        cls_valid;
    rate_cls_t   cls;
    logic        timeout;

    assign per_ext = 32'(period_q);

    always_comb begin
        hits    = '0;
        cls_idx = '0;
        for (int i = 0; i < N_FS; i++) begin
            if (per_ext >= win_lo(CLK_HZ, FS_TAB[i]) &&
                per_ext <= win_hi(CLK_HZ, FS_TAB[i])) begin
                hits    = hits + 4'd1;
                cls_idx = 3'(i);
            end
        end
        cls_valid = (hits == 4'd1);
        cls       = idx_cls(cls_idx);
    end

    always_comb begin
        timeout   = &cnt_q;
        cnt_d     = timeout ? cnt_q : cnt_q + CNT_W'(1);
        armed_d   = timeout ? 1'b0 : armed_q;
        period_d  = period_q;
        meas_d    = 1'b0;
        state_d   = state_q;
        cand_d    = cand_q;
        hit_d     = hit_q;
        miss_d    = miss_q;
        bitrate_d = bitrate_q;
        fam_d     = fam_q;
        locked_d  = locked_q;
        update_d  = 1'b0;
        // A saturated count is never a usable period, so it is not captured.
        if (edge_p) begin
            if (armed_q && !timeout) begin
                period_d = cnt_q;
                meas_d   = 1'b1;
            end
            cnt_d   = CNT_W'(1);
            armed_d = 1'b1;
        end
        if (timeout) begin
            state_d  = ACQ;
            locked_d = 1'b0;
            hit_d    = '0;
        end else if (meas_q) begin
            unique case (state_q)
                ACQ: begin
                    if (!cls_valid) begin
                        hit_d = '0;
                    end else if (cls == cand_q) begin
                        hit_d = hit_q + HW'(1);
                    end else begin
                        cand_d = cls;
                        hit_d  = HW'(1);
                    end
                    if (hit_d == HW'(LOCK_N)) begin
                        state_d   = LOCK;
                        bitrate_d = cand_d.rate;
                        fam_d     = cand_d.fam;
                        locked_d  = 1'b1;
                        update_d  = 1'b1;
                        miss_d    = '0;
                    end
                end
                LOCK: begin
                    if (cls_valid && cls == cand_q) miss_d = '0;
                    else miss_d = miss_q + MW'(1);
                    if (miss_d == MW'(UNLOCK_N)) begin
                        state_d  = ACQ;
                        locked_d = 1'b0;
                        hit_d    = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ACQ;
            cnt_q     <= '0;
            armed_q   <= 1'b0;
            period_q  <= '0;
            meas_q    <= 1'b0;
            cand_q    <= '0;
            hit_q     <= '0;
            miss_q    <= '0;
            bitrate_q <= FS_1X;
            fam_q     <= 1'b0;
            locked_q  <= 1'b0;
            update_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            period_q  <= period_d;
            meas_q    <= meas_d;
            cand_q    <= cand_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            bitrate_q <= bitrate_d;
            fam_q     <= fam_d;
            locked_q  <= locked_d;
            update_q  <= update_d;
        end
    end

    assign bus.bitrate = bitrate_q;
    assign bus.fam_48  = fam_q;
    assign bus.locked  = locked_q;
    assign bus.period  = period_q;
    assign bus.update  = update_q;
endmodule

// File: tb/tb_i2s_rate_detect.sv
// Directed scenario bench for i2s_rate_detect at CLK_HZ = 49.152 MHz.
module tb_i2s_rate_detect;
    import snos_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic lk_prev = 1'b0;
    int cyc = 0;
    int passed = 0;
    int total = 0;
    int upd_cnt = 0;
    int unl_cnt = 0;
    int rise_cyc = 0;

    i2s_rate_detect_if #(.CNT_W(12)) bus ();

    i2s_rate_detect #(
        .CLK_HZ   (49_152_000),
        .CNT_W    (12),
        .LOCK_N   (4),
        .UNLOCK_N (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.update === 1'b1) upd_cnt++;
        if (lk_prev === 1'b1 && bus.locked === 1'b0) unl_cnt++;
        lk_prev = bus.locked;
    end

    initial begin
        #(200_000 * 10);
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    // Entered and left 1 ns after a posedge; rises are spaced p clocks apart.
    task automatic lrck_edges(input int p, input int n);
        for (int k = 0; k < n; k++) begin
            bus.lrck = 1'b1;
            rise_cyc = cyc;
            repeat (p / 2) @(posedge clk);
            #1;
            bus.lrck = 1'b0;
            repeat (p - p / 2) @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        bus.lrck = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.bitrate !== FS_1X) $display("FAIL rst_bitrate: got %0d want 0", bus.bitrate); else passed++;
        total++; if (bus.fam_48 !== 1'b0) $display("FAIL rst_fam: got %0b want 0", bus.fam_48); else passed++;
        total++; if (bus.locked !== 1'b0) $display("FAIL rst_locked: got %0b want 0", bus.locked); else passed++;
        total++; if (bus.period !== 12'd0) $display("FAIL rst_period: got %0d want 0", bus.period); else passed++;
        total++; if (bus.update !== 1'b0) $display("FAIL rst_update: got %0b want 0", bus.update); else passed++;
    endtask

    task automatic test_lock48();
        int u0;
        do_reset();
        u0 = upd_cnt;
        lrck_edges(1024, 4);
        total++; if (bus.locked !== 1'b0) $display("FAIL l48_early: got %0b want 0", bus.locked); else passed++;
        lrck_edges(1024, 2);
        total++; if (bus.locked !== 1'b1) $display("FAIL l48_locked: got %0b want 1", bus.locked); else passed++;
        total++; if (bus.bitrate !== FS_1X) $display("FAIL l48_bitrate: got %0d want 0", bus.bitrate); else passed++;
        total++; if (bus.fam_48 !== 1'b1) $display("FAIL l48_fam: got %0b want 1", bus.fam_48); else passed++;
        total++; if (bus.period !== 12'd1024) $display("FAIL l48_period: got %0d want 1024", bus.period); else passed++;
        total++; if (upd_cnt - u0 != 1) $display("FAIL l48_update: got %0d pulses want 1", upd_cnt - u0); else passed++;
    endtask

    task automatic test_jitter176();
        int u0, x0;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            lrck_edges(278, 1);
            lrck_edges(279, 1);
        end
        total++; if (bus.locked !== 1'b1) $display("FAIL j176_locked: got %0b want 1", bus.locked); else passed++;
        total++; if (bus.bitrate !== FS_4X) $display("FAIL j176_bitrate: got %0d want 2", bus.bitrate); else passed++;
        total++; if (bus.fam_48 !== 1'b0) $display("FAIL j176_fam: got %0b want 0", bus.fam_48); else passed++;
        u0 = upd_cnt;
        x0 = unl_cnt;
        for (int k = 0; k < 50; k++) begin
            lrck_edges(278, 1);
            lrck_edges(279, 1);
        end
        total++; if (unl_cnt - x0 != 0) $display("FAIL j176_unlock: got %0d drops want 0", unl_cnt - x0); else passed++;
        total++; if (bus.locked !== 1'b1) $display("FAIL j176_hold: got %0b want 1", bus.locked); else passed++;
        total++; if (upd_cnt - u0 != 0) $display("FAIL j176_update: got %0d pulses want 0", upd_cnt - u0); else passed++;
    endtask

    task automatic test_glitch();
        int u0, x0;
        do_reset();
        lrck_edges(512, 6);
        total++; if (bus.locked !== 1'b1) $display("FAIL gl_locked: got %0b want 1", bus.locked); else passed++;
        total++; if (bus.bitrate !== FS_2X) $display("FAIL gl_bitrate: got %0d want 1", bus.bitrate); else passed++;
        u0 = upd_cnt;
        x0 = unl_cnt;
        lrck_edges(600, 1);
        lrck_edges(512, 4);
        total++; if (bus.locked !== 1'b1) $display("FAIL gl_hold: got %0b want 1", bus.locked); else passed++;
        total++; if (unl_cnt - x0 != 0) $display("FAIL gl_unlock: got %0d drops want 0", unl_cnt - x0); else passed++;
        total++; if (upd_cnt - u0 != 0) $display("FAIL gl_update: got %0d pulses want 0", upd_cnt - u0); else passed++;
    endtask

    task automatic test_rate_change();
        int u0;
        do_reset();
        lrck_edges(1024, 6);
        u0 = upd_cnt;
        // First 512 rise still closes a 1024 period; the second is the first 512 measurement.
        lrck_edges(512, 2);
        total++; if (bus.locked !== 1'b1) $display("FAIL rc_one_miss: got %0b want 1", bus.locked); else passed++;
        lrck_edges(512, 1);
        total++; if (bus.locked !== 1'b0) $display("FAIL rc_unlock: got %0b want 0", bus.locked); else passed++;
        total++; if (bus.bitrate !== FS_1X) $display("FAIL rc_hold_rate: got %0d want 0", bus.bitrate); else passed++;
        total++; if (bus.fam_48 !== 1'b1) $display("FAIL rc_hold_fam: got %0b want 1", bus.fam_48); else passed++;
        lrck_edges(512, 3);
        total++; if (bus.locked !== 1'b0) $display("FAIL rc_three: got %0b want 0", bus.locked); else passed++;
        lrck_edges(512, 1);
        total++; if (bus.locked !== 1'b1) $display("FAIL rc_relock: got %0b want 1", bus.locked); else passed++;
        total++; if (bus.bitrate !== FS_2X) $display("FAIL rc_bitrate: got %0d want 1", bus.bitrate); else passed++;
        total++; if (bus.fam_48 !== 1'b1) $display("FAIL rc_fam: got %0b want 1", bus.fam_48); else passed++;
        total++; if (upd_cnt - u0 != 1) $display("FAIL rc_update: got %0d pulses want 1", upd_cnt - u0); else passed++;
    endtask

    task automatic test_stop();
        int u0, t0;
        do_reset();
        lrck_edges(1024, 6);
        total++; if (bus.locked !== 1'b1) $display("FAIL st_locked: got %0b want 1", bus.locked); else passed++;
        t0 = rise_cyc;
        for (int i = 0; i < 6000; i++) begin
            if (bus.locked !== 1'b1) break;
            @(posedge clk);
            #1;
        end
        // Edge pulse trails the LRCK drive by 2 clk, timeout fires 4096 clk after it.
        total++; if (cyc - t0 != 4098) $display("FAIL st_timeout: got %0d clk want 4098", cyc - t0); else passed++;
        u0 = upd_cnt;
        lrck_edges(800, 8);
        total++; if (bus.locked !== 1'b0) $display("FAIL st_800_lock: got %0b want 0", bus.locked); else passed++;
        total++; if (bus.period !== 12'd800) $display("FAIL st_800_period: got %0d want 800", bus.period); else passed++;
        total++; if (upd_cnt - u0 != 0) $display("FAIL st_800_update: got %0d pulses want 0", upd_cnt - u0); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        lrck_edges(128, 6);
        total++; if (bus.locked !== 1'b1) $display("FAIL rm_locked: got %0b want 1", bus.locked); else passed++;
        total++; if (bus.bitrate !== FS_8X) $display("FAIL rm_bitrate: got %0d want 3", bus.bitrate); else passed++;
        total++; if (bus.fam_48 !== 1'b1) $display("FAIL rm_fam: got %0b want 1", bus.fam_48); else passed++;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        total++; if (bus.locked !== 1'b0) $display("FAIL rm_rst_locked: got %0b want 0", bus.locked); else passed++;
        total++; if (bus.bitrate !== FS_1X) $display("FAIL rm_rst_bitrate: got %0d want 0", bus.bitrate); else passed++;
        total++; if (bus.fam_48 !== 1'b0) $display("FAIL rm_rst_fam: got %0b want 0", bus.fam_48); else passed++;
        total++; if (bus.period !== 12'd0) $display("FAIL rm_rst_period: got %0d want 0", bus.period); else passed++;
        lrck_edges(128, 4);
        total++; if (bus.locked !== 1'b0) $display("FAIL rm_three: got %0b want 0", bus.locked); else passed++;
        lrck_edges(128, 1);
        total++; if (bus.locked !== 1'b1) $display("FAIL rm_relock: got %0b want 1", bus.locked); else passed++;
        total++; if (bus.bitrate !== FS_8X) $display("FAIL rm_rebitrate: got %0d want 3", bus.bitrate); else passed++;
    endtask

    initial begin
        bus.lrck = 1'b0;
        test_reset();
        test_lock48();
        test_jitter176();
        test_glitch();
        test_rate_change();
        test_stop();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
